// File: rtl/acortex_codec_cfg_seq.sv
// WM8731 configuration sequencer: walks an 11-entry register table through the
// acortex I2C master with retry, timeout and settle handling.
module acortex_codec_cfg_seq #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         MAX_RETRY      = 3,
    parameter int         SETTLE_CYCLES  = 1024,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_start,
    output logic        i2c_wr_en,
    output logic [6:0]  i2c_dev_addr,
    output logic [15:0] i2c_data,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [3:0]  cur_idx
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, DONE, ERR} state_t;

    localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state;
    logic [3:0]  idx;
    logic [2:0]  retry;
    logic [15:0] cnt;

    // Register table packed as {reg_addr[6:0], reg_data[8:0]}.
    function automatic logic [15:0] cfg_word(input logic [3:0] i);
        logic [6:0] a;
        logic [8:0] d;
        case (i)
            4'd0:    begin a = 7'h0F; d = 9'h000; end
            4'd1:    begin a = 7'h00; d = 9'h017; end
            4'd2:    begin a = 7'h01; d = 9'h017; end
            4'd3:    begin a = 7'h02; d = 9'h079; end
            4'd4:    begin a = 7'h03; d = 9'h079; end
            4'd5:    begin a = 7'h04; d = 9'h012; end
            4'd6:    begin a = 7'h05; d = 9'h000; end
            4'd7:    begin a = 7'h06; d = 9'h000; end
            4'd8:    begin a = 7'h07; d = 9'h002; end
            4'd9:    begin a = 7'h08; d = 9'h000; end
            4'd10:   begin a = 7'h09; d = 9'h001; end
            default: begin a = 7'h0F; d = 9'h000; end
        endcase
        return {a, d};
    endfunction

    assign i2c_dev_addr = DEV_ADDR;
    assign cur_idx      = idx;

    // cnt holds the WAIT timeout age (starting at 2 so expiry lands TIMEOUT_CYCLES
    // after the write pulse, counting the re-issue) or the SETTLE elapsed count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            retry     <= 3'd0;
            cnt       <= 16'd0;
            i2c_wr_en <= 1'b0;
            i2c_data  <= cfg_word(4'd0);
            init_busy <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            i2c_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= ISSUE;
                    init_busy <= 1'b1;
                end
                ISSUE: begin
                    if (!i2c_busy) begin
                        i2c_wr_en <= 1'b1;
                        cnt       <= 16'd2;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (i2c_done && !i2c_nack) begin
                        retry <= 3'd0;
                        if (idx == 4'd0 || idx == 4'd9) begin
                            cnt   <= 16'd0;
                            state <= SETTLE;
                        end else if (idx == 4'd10) begin
                            state     <= DONE;
                            init_done <= 1'b1;
                            init_busy <= 1'b0;
                        end else begin
                            idx      <= idx + 4'd1;
                            i2c_data <= cfg_word(idx + 4'd1);
                            state    <= ISSUE;
                        end
                    end else if (i2c_done || cnt == TMO_LIMIT) begin
                        retry <= retry + 3'd1;
                        if (retry + 3'd1 == RETRY_LIMIT) begin
                            state     <= ERR;
                            init_err  <= 1'b1;
                            init_busy <= 1'b0;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        idx      <= idx + 4'd1;
                        i2c_data <= cfg_word(idx + 4'd1);
                        state    <= ISSUE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE, ERR: begin
                    if (init_start) begin
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        init_busy <= 1'b1;
                        idx       <= 4'd0;
                        retry     <= 3'd0;
                        i2c_data  <= cfg_word(4'd0);
                        state     <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acortex_codec_cfg_seq.sv
// Bench for acortex_codec_cfg_seq: scripted I2C slave with random latency,
// event-timed reference model checked every cycle, plus literal anchor checks.
module tb_acortex_codec_cfg_seq;

    localparam int S  = 40;
    localparam int T  = 100;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_wr_en;
    logic [6:0]  i2c_dev_addr;
    logic [15:0] i2c_data;
    logic        init_busy, init_done, init_err;
    logic [3:0]  cur_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int scen  = 0;
    int hold_cfg = 0;
    int inj_req = 0;
    int log_cyc[$];
    logic [15:0] log_data[$];

    int unsigned tbl_addr[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int unsigned tbl_data[11] = '{0, 'h17, 'h17, 'h79, 'h79, 'h12, 0, 0, 2, 0, 1};
    logic [15:0] exp_seq[11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                                 16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

    acortex_codec_cfg_seq #(
        .DEV_ADDR(7'h1A), .MAX_RETRY(MR), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .i2c_wr_en(i2c_wr_en), .i2c_dev_addr(i2c_dev_addr), .i2c_data(i2c_data),
        .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
        .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] word_of(input int i);
        return 16'((tbl_addr[i] << 9) | tbl_data[i]);
    endfunction

    function automatic int entry_of(input logic [15:0] w);
        int a;
        a = int'(w[15:9]);
        if (a == 15) return 0;
        if (a <= 9) return a + 1;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic start_val);
        @(posedge clk);
        #1;
        rst_n      = rst_val;
        init_start = start_val;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        checkOutput("writesReached", 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic wait_ack(input int budget);
        int k = 0;
        while (!i2c_done && k < budget) begin
            @(negedge clk); #1; k++;
        end
        checkOutput("ackSeen", 32'(i2c_done), 32'd1);
    endtask

    task automatic wait_finish(input int budget);
        int k = 0;
        while (!(init_done || init_err) && k < budget) begin
            @(negedge clk); #1; k++;
        end
        checkOutput("seqEnded", 32'(init_done || init_err), 32'd1);
        repeat (5) @(posedge clk);
    endtask

    // Scripted slave: random ack latency, busy while a transfer is outstanding,
    // per-scenario NACK/drop behaviour keyed on the entry decoded from i2c_data.
    initial begin : responder
        int pend, extra, hold, last_scen, inj_ack, e, a;
        int att[11];
        bit pend_nack, drop;
        pend = 0; extra = 0; hold = 0; last_scen = -1; inj_ack = 0; pend_nack = 0;
        foreach (att[k]) att[k] = 0;
        forever begin
            @(posedge clk);
            #2;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (scen != last_scen) begin
                last_scen = scen;
                foreach (att[k]) att[k] = 0;
            end
            if (!rst_n) begin
                pend = 0; extra = 0; hold = hold_cfg;
                i2c_busy = (hold > 0);
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i2c_done = 1'b1;
                        i2c_nack = pend_nack;
                        extra = $urandom_range(3, 0);
                    end
                end else if (extra > 0) begin
                    extra--;
                end else if (inj_req != inj_ack) begin
                    inj_ack++;
                    i2c_done = 1'b1;
                end
                if (i2c_wr_en) begin
                    e = entry_of(i2c_data);
                    a = att[e];
                    att[e]++;
                    drop = (scen == 3 && e == 2 && a == 0);
                    pend_nack = (scen == 1 && e == 4 && a < 2) || (scen == 2 && e == 6);
                    pend = drop ? 0 : $urandom_range(25, 3);
                end
                if (hold > 0) begin
                    hold--;
                    i2c_busy = 1'b1;
                end else begin
                    i2c_busy = (pend > 0) || (extra > 0);
                end
            end
        end
    end

    // Reference model: tracks when the next write becomes eligible from the
    // turnaround/settle/timeout rules and checks every output on every cycle.
    initial begin : compare
        bit m_run, pend_iss, outst, m_done, m_err, m_busy, prev_busy, exp_wr;
        int m_idx, fails, issue_at, wr_at, bump_at;
        m_run = 0; pend_iss = 0; outst = 0; m_done = 0; m_err = 0; m_busy = 0;
        prev_busy = 1; m_idx = 0; fails = 0; issue_at = 0; wr_at = 0; bump_at = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_run = 0; pend_iss = 0; outst = 0; m_done = 0; m_err = 0;
                m_busy = 0; m_idx = 0; fails = 0; bump_at = -1;
            end
            if (bump_at == cyc) begin
                m_idx++;
                bump_at = -1;
            end
            exp_wr = pend_iss && (cyc >= issue_at) && !prev_busy;
            checkOutput("wrEn", 32'(i2c_wr_en), 32'(exp_wr));
            checkOutput("i2cData", 32'(i2c_data), 32'(word_of(m_idx)));
            checkOutput("curIdx", 32'(cur_idx), 32'(m_idx));
            checkOutput("initBusy", 32'(init_busy), 32'(m_busy));
            checkOutput("initDone", 32'(init_done), 32'(m_done));
            checkOutput("initErr", 32'(init_err), 32'(m_err));
            checkOutput("devAddr", 32'(i2c_dev_addr), 32'h1A);
            if (i2c_wr_en) begin
                log_cyc.push_back(cyc);
                log_data.push_back(i2c_data);
            end
            if (rst_n) begin
                if (!m_run) begin
                    m_run = 1; m_busy = 1; pend_iss = 1; issue_at = cyc + 2;
                end else begin
                    if (exp_wr) begin
                        pend_iss = 0; outst = 1; wr_at = cyc;
                    end
                    if (outst && i2c_done && !i2c_nack) begin
                        outst = 0; fails = 0;
                        if (m_idx == 10) begin
                            m_done = 1; m_busy = 0;
                        end else if (m_idx == 0 || m_idx == 9) begin
                            bump_at = cyc + S + 1; pend_iss = 1; issue_at = cyc + S + 2;
                        end else begin
                            m_idx++; pend_iss = 1; issue_at = cyc + 2;
                        end
                    end else if (outst && (i2c_done || cyc == wr_at + T - 2)) begin
                        outst = 0; fails++;
                        if (fails == MR) begin
                            m_err = 1; m_busy = 0;
                        end else begin
                            pend_iss = 1; issue_at = cyc + 2;
                        end
                    end else if ((m_done || m_err) && init_start) begin
                        m_done = 0; m_err = 0; m_busy = 1; m_idx = 0; fails = 0;
                        pend_iss = 1; issue_at = cyc + 2;
                    end
                end
            end
            prev_busy = i2c_busy;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int r, b, m, n;
        hold_cfg = 50;
        scen = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstWrEn", 32'(i2c_wr_en), 32'd0);
        checkOutput("rstData", 32'(i2c_data), 32'h1E00);
        checkOutput("rstBusy", 32'(init_busy), 32'd0);
        checkOutput("rstDone", 32'(init_done), 32'd0);
        checkOutput("rstErr", 32'(init_err), 32'd0);
        checkOutput("rstIdx", 32'(cur_idx), 32'd0);

        $display("[TB] auto-start with busy held, spurious done, mid-sequence init_start");
        applyStimulus(1'b1, 1'b0);
        r = cyc;
        wait_writes(1, 500);
        checkOutput("firstWrCycle", 32'(log_cyc[0]), 32'(r + 51));
        wait_ack(100);
        repeat (3) @(posedge clk);
        inj_req++;
        wait_writes(5, 2000);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        wait_finish(3000);
        checkOutput("countA", 32'(log_data.size()), 32'd11);
        for (int i = 0; i < 11 && i < log_data.size(); i++)
            checkOutput($sformatf("seqA%0d", i), 32'(log_data[i]), 32'(exp_seq[i]));
        if (log_data.size() >= 11) begin
            checkOutput("settleGap0", 32'(log_cyc[1] - log_cyc[0] >= S), 32'd1);
            checkOutput("settleGap9", 32'(log_cyc[10] - log_cyc[9] >= S), 32'd1);
        end
        checkOutput("doneA", 32'(init_done), 32'd1);
        checkOutput("errA", 32'(init_err), 32'd0);

        $display("[TB] replay via init_start, entry 4 nacked twice");
        scen = 1;
        b = log_data.size();
        applyStimulus(1'b1, 1'b1);
        m = cyc;
        applyStimulus(1'b1, 1'b0);
        wait_finish(3000);
        checkOutput("countB", 32'(log_data.size() - b), 32'd13);
        if (log_data.size() > b)
            checkOutput("restartWrCycle", 32'(log_cyc[b]), 32'(m + 2));
        n = 0;
        for (int i = b; i < log_data.size(); i++) if (log_data[i] == 16'h0679) n++;
        checkOutput("retries4", 32'(n), 32'd3);
        checkOutput("doneB", 32'(init_done), 32'd1);

        $display("[TB] entry 6 always nacked");
        scen = 2;
        b = log_data.size();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        wait_finish(3000);
        checkOutput("countC", 32'(log_data.size() - b), 32'd9);
        n = 0;
        for (int i = b; i < log_data.size(); i++) if (log_data[i] == 16'h0A00) n++;
        checkOutput("retries6", 32'(n), 32'd3);
        checkOutput("errC", 32'(init_err), 32'd1);
        checkOutput("doneC", 32'(init_done), 32'd0);
        checkOutput("idxC", 32'(cur_idx), 32'd6);
        checkOutput("busyC", 32'(init_busy), 32'd0);
        repeat (200) @(posedge clk);
        checkOutput("quietAfterErr", 32'(log_data.size() - b), 32'd9);

        $display("[TB] entry 2 done dropped once");
        scen = 3;
        b = log_data.size();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        wait_finish(3000);
        checkOutput("countD", 32'(log_data.size() - b), 32'd12);
        if (log_data.size() >= b + 4) begin
            checkOutput("dropData", 32'(log_data[b + 3]), 32'h0217);
            checkOutput("timeoutGap", 32'(log_cyc[b + 3] - log_cyc[b + 2]), 32'(T));
        end
        checkOutput("doneD", 32'(init_done), 32'd1);

        $display("[TB] reset during settle after entry 0");
        scen = 4;
        hold_cfg = 0;
        b = log_data.size();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        wait_writes(b + 1, 500);
        wait_ack(100);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncWrEn", 32'(i2c_wr_en), 32'd0);
        checkOutput("asyncBusy", 32'(init_busy), 32'd0);
        checkOutput("asyncData", 32'(i2c_data), 32'h1E00);
        checkOutput("asyncIdx", 32'(cur_idx), 32'd0);
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 1'b0);
        b = log_data.size();
        wait_finish(3000);
        checkOutput("countE", 32'(log_data.size() - b), 32'd11);
        if (log_data.size() > b)
            checkOutput("reissue0", 32'(log_data[b]), 32'h1E00);
        checkOutput("doneE", 32'(init_done), 32'd1);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
